mem_stage_lsu: RTL and testbench

- Parametrised RV32 pipeline memory stage with a registered MEM/WB boundary.
- Supports all RV32I load/store widths: LB/LH/LW/LBU/LHU and SB/SH/SW.
- Generates byte enables and sign/zero-extends load data.
- Talks to a variable-latency data memory through a req/rvalid handshake and stalls upstream while an access is outstanding.
- Sits between EX and WB; non-memory instructions pass straight through with one-cycle latency.

---
 rtl/mem_stage_lsu.sv | 181 ++++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_lsu.sv
// rtl/mem_stage_lsu.sv - RV32 memory stage: load/store lane handling, dmem handshake, MEM/WB register
// Optional: MEM_STAGE_MISALIGN_TRAP_EN traps misaligned H/W accesses instead of issuing them.
module mem_stage_lsu #(
  parameter int XLEN     = 32,
  parameter int REG_W    = 5,
  parameter int MAX_WAIT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             MemWrite,
  input  logic             MemRead,
  input  logic [2:0]       funct3,
  input  logic [1:0]       ResultSrc,
  input  logic [XLEN-1:0]  ALUResult,
  input  logic [XLEN-1:0]  rs2_data,
  input  logic [REG_W-1:0] rd_in,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [XLEN-1:0]  dmem_addr,
  output logic [XLEN/8-1:0] dmem_be,
  output logic [XLEN-1:0]  dmem_wdata,
  input  logic             dmem_rvalid,
  input  logic [XLEN-1:0]  dmem_rdata,
  output logic             wb_valid,
  output logic [XLEN-1:0]  wb_ReadData,
  output logic [XLEN-1:0]  wb_ALUResult,
  output logic [REG_W-1:0] wb_rd,
  output logic [1:0]       wb_ResultSrc,
  output logic             mem_err
);
  localparam int NB = XLEN / 8;
  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;
  localparam logic [1:0] SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2;

  logic [0:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             rd_en_q, wr_en_q;
  logic [2:0]       f3_q;
  logic [1:0]       rsrc_q;
  logic [XLEN-1:0]  alu_q, rs2_q;
  logic [REG_W-1:0] rd_q;
  logic             wb_valid_q, mem_err_q;
  logic [XLEN-1:0]  wb_rdata_q, wb_rdata_d, wb_alu_q;
  logic [REG_W-1:0] wb_rd_q;
  logic [1:0]       wb_rsrc_q;

  logic             in_idle, cur_rd, cur_wr, accept_mem, misal, trap, timeout, done, err_d;
  logic [2:0]       cur_f3;
  logic [1:0]       cur_a, sz;
  logic [XLEN-1:0]  cur_alu, cur_rs2, ext;
  logic [7:0]       rbyte;
  logic [15:0]      rhalf;
  logic             sgn;

  always_comb begin
    in_idle = (state_q == IDLE);
    // In WAIT the captured instruction drives everything so the request stays stable.
    cur_rd  = in_idle ? MemRead   : rd_en_q;
    cur_wr  = in_idle ? MemWrite  : wr_en_q;
    cur_f3  = in_idle ? funct3    : f3_q;
    cur_alu = in_idle ? ALUResult : alu_q;
    cur_rs2 = in_idle ? rs2_data  : rs2_q;
    cur_a   = cur_alu[1:0];
    case (cur_f3)
      3'b000, 3'b100: sz = SZ_B;
      3'b001, 3'b101: sz = SZ_H;
      default:        sz = SZ_W;
    endcase
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    misal = ((sz == SZ_H) && cur_a[0]) || ((sz == SZ_W) && (cur_a != 2'b00));
`else
    misal = 1'b0;
`endif
    accept_mem = in_idle && in_valid && (MemRead || MemWrite);
    trap       = accept_mem && misal;
    dmem_req   = in_idle ? (accept_mem && !misal) : 1'b1;
    dmem_we    = dmem_req && cur_wr;
    dmem_addr  = dmem_req ? {cur_alu[XLEN-1:2], 2'b00} : '0;
    dmem_be    = '0;
    dmem_wdata = '0;
    if (dmem_req) begin
      case (sz)
        SZ_B: begin
          dmem_be    = NB'(1) << cur_a;
          dmem_wdata = {NB{cur_rs2[7:0]}};
        end
        SZ_H: begin
          dmem_be    = cur_a[1] ? 4'b1100 : 4'b0011;
          dmem_wdata = {2{cur_rs2[15:0]}};
        end
        default: begin
          dmem_be    = {NB{1'b1}};
          dmem_wdata = cur_rs2;
        end
      endcase
    end

    rbyte = dmem_rdata[{cur_a, 3'b000} +: 8];
    rhalf = cur_a[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    sgn   = !cur_f3[2];
    case (sz)
      SZ_B:    ext = {{(XLEN-8){sgn && rbyte[7]}}, rbyte};
      SZ_H:    ext = {{(XLEN-16){sgn && rhalf[15]}}, rhalf};
      default: ext = dmem_rdata;
    endcase

    timeout = !in_idle && !dmem_rvalid && (cnt_q == CW'(MAX_WAIT));
    done    = in_idle ? (in_valid && (!(MemRead || MemWrite) || trap || dmem_rvalid))
                      : (dmem_rvalid || timeout);
    err_d   = trap || timeout;
    // Both strobes set is a store; only a true load that got its data returns it.
    wb_rdata_d = (cur_rd && !cur_wr && dmem_rvalid && !err_d && (in_idle ? accept_mem : 1'b1))
                 ? ext : '0;

    state_d = state_q;
    cnt_d   = cnt_q;
    if (in_idle) begin
      if (accept_mem && !misal && !dmem_rvalid) begin
        state_d = WAIT;
        cnt_d   = CW'(1);
      end
    end else if (done) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rd_en_q    <= 1'b0;
      wr_en_q    <= 1'b0;
      f3_q       <= '0;
      rsrc_q     <= '0;
      alu_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      wb_valid_q <= 1'b0;
      mem_err_q  <= 1'b0;
      wb_rdata_q <= '0;
      wb_alu_q   <= '0;
      wb_rd_q    <= '0;
      wb_rsrc_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wb_valid_q <= done;
      mem_err_q  <= err_d;
      if (in_idle && in_valid) begin
        rd_en_q <= MemRead;
        wr_en_q <= MemWrite;
        f3_q    <= funct3;
        rsrc_q  <= ResultSrc;
        alu_q   <= ALUResult;
        rs2_q   <= rs2_data;
        rd_q    <= rd_in;
      end
      if (done) begin
        wb_rdata_q <= wb_rdata_d;
        wb_alu_q   <= cur_alu;
        wb_rd_q    <= in_idle ? rd_in : rd_q;
        wb_rsrc_q  <= in_idle ? ResultSrc : rsrc_q;
      end
    end
  end

  assign in_ready     = (state_q == IDLE);
  assign wb_valid     = wb_valid_q;
  assign wb_ReadData  = wb_rdata_q;
  assign wb_ALUResult = wb_alu_q;
  assign wb_rd        = wb_rd_q;
  assign wb_ResultSrc = wb_rsrc_q;
  assign mem_err      = mem_err_q;
endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb/tb_mem_stage_lsu.sv - directed vector bench for mem_stage_lsu
module tb_mem_stage_lsu;
  logic        clk, rst_n;
  logic        in_valid, in_ready, MemWrite, MemRead;
  logic [2:0]  funct3;
  logic [1:0]  ResultSrc;
  logic [31:0] ALUResult, rs2_data;
  logic [4:0]  rd_in;
  logic        dmem_req, dmem_we, dmem_rvalid;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        wb_valid, mem_err;
  logic [31:0] wb_ReadData, wb_ALUResult;
  logic [4:0]  wb_rd;
  logic [1:0]  wb_ResultSrc;

  int checks = 0;
  int failures = 0;

  mem_stage_lsu dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .MemWrite(MemWrite), .MemRead(MemRead), .funct3(funct3), .ResultSrc(ResultSrc),
    .ALUResult(ALUResult), .rs2_data(rs2_data), .rd_in(rd_in),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_ReadData(wb_ReadData), .wb_ALUResult(wb_ALUResult),
    .wb_rd(wb_rd), .wb_ResultSrc(wb_ResultSrc), .mem_err(mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rd_en, wr_en;
    logic [2:0]  f3;
    logic [31:0] alu, rs2;
    logic [4:0]  rd;
    logic [1:0]  rsrc;
    int          lat;
    logic [31:0] rdata;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic w, input logic [2:0] f3,
                              input logic [31:0] alu, input logic [31:0] rs2,
                              input logic [4:0] rd, input logic [1:0] rsrc, input int lat,
                              input logic [31:0] rdata, input logic [31:0] ea,
                              input logic [3:0] ebe, input logic [31:0] ewd,
                              input logic [31:0] erd);
    vec_t v;
    v.rd_en = r; v.wr_en = w; v.f3 = f3; v.alu = alu; v.rs2 = rs2; v.rd = rd;
    v.rsrc = rsrc; v.lat = lat; v.rdata = rdata; v.e_addr = ea; v.e_be = ebe;
    v.e_wdata = ewd; v.e_rdata = erd;
    return v;
  endfunction

  task automatic idle_inputs();
    in_valid = 0; MemRead = 0; MemWrite = 0; funct3 = 0; ResultSrc = 0;
    ALUResult = 0; rs2_data = 0; rd_in = 0; dmem_rvalid = 0; dmem_rdata = 0;
  endtask

  // Called #1 after a rising edge; returns #1 after the edge following the bubble check.
  task automatic run_vec(input int i, input vec_t v);
    logic mem;
    mem = v.rd_en | v.wr_en;
    in_valid = 1; MemRead = v.rd_en; MemWrite = v.wr_en; funct3 = v.f3;
    ResultSrc = v.rsrc; ALUResult = v.alu; rs2_data = v.rs2; rd_in = v.rd;
    if (mem && v.lat == 0) begin dmem_rvalid = 1; dmem_rdata = v.rdata; end
    #1;
    chk($sformatf("v%0d_ready0", i), in_ready, 1);
    chk($sformatf("v%0d_req", i), dmem_req, mem);
    if (mem) begin
      chk($sformatf("v%0d_we", i), dmem_we, v.wr_en);
      chk($sformatf("v%0d_addr", i), dmem_addr, v.e_addr);
      chk($sformatf("v%0d_be", i), dmem_be, v.e_be);
      chk($sformatf("v%0d_wdata", i), dmem_wdata, v.e_wdata);
    end
    @(posedge clk); #1;
    idle_inputs();
    if (mem) begin
      for (int k = 1; k <= v.lat; k++) begin
        chk($sformatf("v%0d_w%0d_ready", i, k), in_ready, 0);
        chk($sformatf("v%0d_w%0d_req", i, k), dmem_req, 1);
        chk($sformatf("v%0d_w%0d_addr", i, k), dmem_addr, v.e_addr);
        chk($sformatf("v%0d_w%0d_be", i, k), dmem_be, v.e_be);
        chk($sformatf("v%0d_w%0d_wdata", i, k), dmem_wdata, v.e_wdata);
        chk($sformatf("v%0d_w%0d_wbv", i, k), wb_valid, 0);
        if (k == v.lat) begin dmem_rvalid = 1; dmem_rdata = v.rdata; end
        @(posedge clk); #1;
        dmem_rvalid = 0; dmem_rdata = 0;
      end
    end
    chk($sformatf("v%0d_wb_valid", i), wb_valid, 1);
    chk($sformatf("v%0d_wb_rdata", i), wb_ReadData, v.e_rdata);
    chk($sformatf("v%0d_wb_alu", i), wb_ALUResult, v.alu);
    chk($sformatf("v%0d_wb_rd", i), wb_rd, v.rd);
    chk($sformatf("v%0d_wb_rsrc", i), wb_ResultSrc, v.rsrc);
    chk($sformatf("v%0d_err", i), mem_err, 0);
    chk($sformatf("v%0d_ready1", i), in_ready, 1);
    @(posedge clk); #1;
    chk($sformatf("v%0d_bubble", i), wb_valid, 0);
  endtask

  initial begin
    idle_inputs();
    rst_n = 0;
    //        rd wr f3      alu           rs2           rd  rsrc lat rdata         addr          be       wdata         wb_rdata
    vecs.push_back(mk(0, 0, 3'b000, 32'h1234, 32'h0, 5'd7, 2'b00, 0, 32'h0, 32'h0, 4'b0000, 32'h0, 32'h0));
    vecs.push_back(mk(0, 1, 3'b000, 32'h103, 32'hA5, 5'd0, 2'b00, 2, 32'h0, 32'h100, 4'b1000, 32'hA5A5A5A5, 32'h0));
    vecs.push_back(mk(1, 0, 3'b000, 32'h102, 32'h0, 5'd3, 2'b01, 1, 32'h00F00000, 32'h100, 4'b0100, 32'h0, 32'hFFFFFFF0));
    vecs.push_back(mk(1, 0, 3'b100, 32'h102, 32'h0, 5'd4, 2'b01, 3, 32'h00F00000, 32'h100, 4'b0100, 32'h0, 32'h000000F0));
    vecs.push_back(mk(1, 0, 3'b001, 32'h102, 32'h0, 5'd5, 2'b01, 1, 32'h80010000, 32'h100, 4'b1100, 32'h0, 32'hFFFF8001));
    vecs.push_back(mk(1, 0, 3'b101, 32'h102, 32'h0, 5'd6, 2'b01, 0, 32'h80010000, 32'h100, 4'b1100, 32'h0, 32'h00008001));
    vecs.push_back(mk(1, 0, 3'b010, 32'h200, 32'h0, 5'd8, 2'b01, 0, 32'hDEADBEEF, 32'h200, 4'b1111, 32'h0, 32'hDEADBEEF));
    vecs.push_back(mk(0, 1, 3'b001, 32'h006, 32'h1234BEEF, 5'd9, 2'b00, 1, 32'h0, 32'h004, 4'b1100, 32'hBEEFBEEF, 32'h0));
    vecs.push_back(mk(0, 1, 3'b010, 32'h008, 32'hCAFEF00D, 5'd10, 2'b00, 2, 32'h0, 32'h008, 4'b1111, 32'hCAFEF00D, 32'h0));
    vecs.push_back(mk(1, 1, 3'b010, 32'h010, 32'h11223344, 5'd11, 2'b10, 1, 32'hFFFFFFFF, 32'h010, 4'b1111, 32'h11223344, 32'h0));
    vecs.push_back(mk(1, 0, 3'b011, 32'h020, 32'h0, 5'd12, 2'b01, 1, 32'h89ABCDEF, 32'h020, 4'b1111, 32'h0, 32'h89ABCDEF));
    vecs.push_back(mk(1, 0, 3'b000, 32'h003, 32'h0, 5'd13, 2'b01, 0, 32'h80000000, 32'h000, 4'b1000, 32'h0, 32'hFFFFFF80));
    vecs.push_back(mk(0, 0, 3'b010, 32'hFFFF0000, 32'h0, 5'd31, 2'b11, 0, 32'h0, 32'h0, 4'b0000, 32'h0, 32'h0));
`ifndef MEM_STAGE_MISALIGN_TRAP_EN
    vecs.push_back(mk(1, 0, 3'b001, 32'h001, 32'h0, 5'd14, 2'b01, 1, 32'h00007FFF, 32'h000, 4'b0011, 32'h0, 32'h00007FFF));
    vecs.push_back(mk(1, 0, 3'b010, 32'h202, 32'h0, 5'd15, 2'b01, 1, 32'h01020304, 32'h200, 4'b1111, 32'h0, 32'h01020304));
`endif

    #12;
    chk("rst_ready", in_ready, 1);
    chk("rst_req", dmem_req, 0);
    chk("rst_wbv", wb_valid, 0);
    chk("rst_err", mem_err, 0);
    chk("rst_rdata", wb_ReadData, 0);
    chk("rst_alu", wb_ALUResult, 0);
    chk("rst_rd", wb_rd, 0);
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;

    foreach (vecs[i]) run_vec(i, vecs[i]);

    // Timeout: a load that never gets rvalid.
    in_valid = 1; MemRead = 1; funct3 = 3'b010; ALUResult = 32'h40; rd_in = 5'd2;
    @(posedge clk); #1;
    idle_inputs();
    for (int k = 1; k <= 15; k++) begin
      chk($sformatf("to_w%0d_ready", k), in_ready, 0);
      chk($sformatf("to_w%0d_req", k), dmem_req, 1);
      chk($sformatf("to_w%0d_err", k), mem_err, 0);
      @(posedge clk); #1;
    end
    chk("to_err", mem_err, 1);
    chk("to_wbv", wb_valid, 1);
    chk("to_rdata", wb_ReadData, 0);
    chk("to_rd", wb_rd, 2);
    chk("to_ready", in_ready, 1);
    @(posedge clk); #1;
    chk("to_err_pulse", mem_err, 0);
    chk("to_bubble", wb_valid, 0);

    // Reset while an access is outstanding.
    in_valid = 1; MemRead = 1; funct3 = 3'b010; ALUResult = 32'h80; rd_in = 5'd1;
    @(posedge clk); #1;
    idle_inputs();
    chk("rw_in_wait", in_ready, 0);
    #2 rst_n = 0;
    #1;
    chk("rw_req", dmem_req, 0);
    chk("rw_wbv", wb_valid, 0);
    chk("rw_ready", in_ready, 1);
    @(posedge clk); @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    chk("rw_ready_after", in_ready, 1);
    run_vec(100, mk(1, 0, 3'b010, 32'h200, 32'h0, 5'd20, 2'b01, 2, 32'h5555AAAA, 32'h200, 4'b1111, 32'h0, 32'h5555AAAA));

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    in_valid = 1; MemRead = 1; funct3 = 3'b010; ALUResult = 32'h202; rd_in = 5'd3;
    #1;
    chk("mis_req", dmem_req, 0);
    @(posedge clk); #1;
    idle_inputs();
    chk("mis_err", mem_err, 1);
    chk("mis_wbv", wb_valid, 1);
    chk("mis_rdata", wb_ReadData, 0);
    chk("mis_ready", in_ready, 1);
    @(posedge clk); #1;
    chk("mis_err_pulse", mem_err, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
